// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single data-memory port between the CPU
// load/store stage (m0) and an auxiliary master (m1). Each access goes
// through IDLE -> BUSY -> DONE, or straight to ERR when it is misaligned or
// when the memory never answers. The block drives byte enables and
// lane-replicated store data, and it feeds the external load-extension unit.
//
// Handshake: a requester holds mX_req (with its fields) until it sees a
// one-cycle mX_ack, and drops or changes req in the following cycle. A req
// still high in IDLE counts as a new request. mem_ready is only sampled while
// mem_req is high. mX_err and mX_rdata are meaningful only while mX_ack = 1.
module dm_port_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int WAIT_LIMIT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_m0_req,
    input  logic        i_m0_we,
    input  logic [1:0]  i_m0_size,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic        i_m1_req,
    input  logic        i_m1_we,
    input  logic [1:0]  i_m1_size,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    output logic [31:0] o_m0_rdata,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic [31:0] o_m1_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ready,
    output logic [1:0]  o_ext_a,
    output logic [2:0]  o_ext_op,
    output logic [31:0] o_ext_din,
    input  logic [31:0] i_ext_dout,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [7:0] LP_WAIT_LIMIT = 8'(WAIT_LIMIT);

    state_t      r_state;
    logic        r_gnt;       // grantee of the access in flight: 0 = m0, 1 = m1
    logic        r_last;      // last master served; it loses the next tie
    logic        r_we;
    logic [7:0]  r_wait_cnt;

    logic        w_any_req;
    logic        w_pick_m1;
    logic        w_sel_we;
    logic [1:0]  w_sel_size;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_lane_wdata;
    logic [2:0]  w_ext_op;
    logic [7:0]  w_wait_next;
    logic        w_resp;
    logic        w_resp_err;
    logic [31:0] w_resp_data;

    assign w_any_req   = i_m0_req | i_m1_req;
    assign w_wait_next = r_wait_cnt + 8'd1;
    assign o_dbg_state = r_state;

    // Arbitration: a lone requester wins; on a tie m0 wins under fixed
    // priority, otherwise the master served last steps aside.
    always_comb begin
        w_pick_m1 = 1'b0;
        if (i_m0_req && i_m1_req) begin
            w_pick_m1 = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
        end else begin
            w_pick_m1 = i_m1_req;
        end
        w_sel_we    = w_pick_m1 ? i_m1_we    : i_m0_we;
        w_sel_size  = w_pick_m1 ? i_m1_size  : i_m0_size;
        w_sel_addr  = w_pick_m1 ? i_m1_addr  : i_m0_addr;
        w_sel_wdata = w_pick_m1 ? i_m1_wdata : i_m0_wdata;
    end

    // Size decode of the selected request: byte lanes, replicated store data,
    // extension op code and the alignment rule. Size 11 behaves as a word.
    always_comb begin
        w_be         = 4'b1111;
        w_lane_wdata = w_sel_wdata;
        w_ext_op     = 3'b000;
        w_misaligned = |w_sel_addr[1:0];
        case (w_sel_size)
            2'b01: begin
                w_be         = w_sel_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_wdata = {2{w_sel_wdata[15:0]}};
                w_ext_op     = 3'b001;
                w_misaligned = w_sel_addr[0];
            end
            2'b10: begin
                w_be         = 4'b0001 << w_sel_addr[1:0];
                w_lane_wdata = {4{w_sel_wdata[7:0]}};
                w_ext_op     = 3'b010;
                w_misaligned = 1'b0;
            end
            default: begin
                w_be         = 4'b1111;
                w_lane_wdata = w_sel_wdata;
                w_ext_op     = 3'b000;
                w_misaligned = |w_sel_addr[1:0];
            end
        endcase
    end

    // Access sequencer: latches the grantee's request, runs the memory
    // strobe with a wait-state budget and steps to the response state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_gnt       <= 1'b0;
            r_last      <= 1'b1;
            r_we        <= 1'b0;
            r_wait_cnt  <= 8'd0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= 32'd0;
            o_mem_be    <= 4'd0;
            o_mem_wdata <= 32'd0;
            o_ext_a     <= 2'd0;
            o_ext_op    <= 3'd0;
            o_ext_din   <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_gnt    <= w_pick_m1;
                        r_we     <= w_sel_we;
                        o_ext_a  <= w_sel_addr[1:0];
                        o_ext_op <= w_ext_op;
                        if (w_misaligned) begin
                            r_state <= ST_ERR;
                        end else begin
                            r_state     <= ST_BUSY;
                            r_wait_cnt  <= 8'd0;
                            o_mem_req   <= 1'b1;
                            o_mem_we    <= w_sel_we;
                            o_mem_addr  <= {w_sel_addr[31:2], 2'b00};
                            o_mem_be    <= w_be;
                            o_mem_wdata <= w_lane_wdata;
                        end
                    end
                end
                ST_BUSY: begin
                    if (i_mem_ready) begin
                        o_mem_req <= 1'b0;
                        if (!r_we) begin
                            o_ext_din <= i_mem_rdata;
                        end
                        r_state <= ST_DONE;
                    end else begin
                        r_wait_cnt <= w_wait_next;
                        if (w_wait_next == LP_WAIT_LIMIT) begin
                            o_mem_req <= 1'b0;
                            r_state   <= ST_ERR;
                        end
                    end
                end
                ST_DONE: begin
                    r_last  <= r_gnt;
                    r_state <= ST_IDLE;
                end
                ST_ERR: begin
                    r_last  <= r_gnt;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Response steering: only the grantee sees ack; the load result comes
    // from the extension unit, which works on the word latched on mem_ready.
    always_comb begin
        w_resp      = (r_state == ST_DONE) || (r_state == ST_ERR);
        w_resp_err  = (r_state == ST_ERR);
        w_resp_data = ((r_state == ST_DONE) && !r_we) ? i_ext_dout : 32'd0;
        o_m0_ack    = w_resp && !r_gnt;
        o_m0_err    = w_resp && !r_gnt && w_resp_err;
        o_m0_rdata  = (w_resp && !r_gnt) ? w_resp_data : 32'd0;
        o_m1_ack    = w_resp && r_gnt;
        o_m1_err    = w_resp && r_gnt && w_resp_err;
        o_m1_rdata  = (w_resp && r_gnt) ? w_resp_data : 32'd0;
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: a round-robin instance (checked in full) and a
// fixed-priority instance sharing the same stimulus (checked on grant order).
// A memory model answers after a chosen number of wait cycles, and an
// extension-unit model sign-extends the latched word.
module tb_dm_port_arbiter;

    localparam int WL = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
    logic [31:0] o_m0_rdata, o_m1_rdata;
    logic        o_mem_req, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata, mem_rdata;
    logic [3:0]  o_mem_be;
    logic        mem_ready;
    logic [1:0]  o_ext_a, o_dbg_state;
    logic [2:0]  o_ext_op;
    logic [31:0] o_ext_din, ext_dout;

    logic        fx_m0_ack, fx_m0_err, fx_m1_ack, fx_m1_err;
    logic [31:0] fx_m0_rdata, fx_m1_rdata;
    logic        fx_mem_req, fx_mem_we;
    logic [31:0] fx_mem_addr, fx_mem_wdata, fx_mem_rdata;
    logic [3:0]  fx_mem_be;
    logic [1:0]  fx_ext_a, fx_dbg_state;
    logic [2:0]  fx_ext_op;
    logic [31:0] fx_ext_din, fx_ext_dout;

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    int mem_delay = 0;
    int busy_cnt = 0;
    int model_last = 1;

    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [1:0]  ea;
        logic [2:0]  eop;
    } mem_exp_t;
    mem_exp_t mem_q[$];

    // ---------------- reference functions ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:2] == 30'h400) return 32'h80FF_FF00;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic int size_bytes(input logic [1:0] size);
        if (size == 2'b01) return 2;
        if (size == 2'b10) return 1;
        return 4;
    endfunction

    function automatic logic misaligned(input logic [31:0] a, input logic [1:0] size);
        return (int'(a[1:0]) % size_bytes(size)) != 0;
    endfunction

    function automatic logic [31:0] load_result(input logic [31:0] a, input logic [1:0] size);
        logic [31:0] w;
        longint v;
        int n;
        w = mem_word({a[31:2], 2'b00});
        n = size_bytes(size);
        if (n == 4) return w;
        v = longint'((w >> (int'(a[1:0]) * 8)) & ((32'd1 << (n * 8)) - 32'd1));
        if (v >= (longint'(1) << (n * 8 - 1))) v = v - (longint'(1) << (n * 8));
        return 32'(v);
    endfunction

    // Extension unit model driven by the DUT's ext_* outputs.
    function automatic logic [31:0] ext_fn(input logic [31:0] din, input logic [1:0] a,
                                           input logic [2:0] op);
        logic [31:0] s;
        s = din >> (int'(a) * 8);
        case (op)
            3'b010:  return {{24{s[7]}}, s[7:0]};
            3'b001: begin
                s = din >> (int'(a[1]) * 16);
                return {{16{s[15]}}, s[15:0]};
            end
            default: return din;
        endcase
    endfunction

    assign mem_rdata    = mem_word(o_mem_addr);
    assign fx_mem_rdata = mem_word(fx_mem_addr);
    assign ext_dout     = ext_fn(o_ext_din, o_ext_a, o_ext_op);
    assign fx_ext_dout  = ext_fn(fx_ext_din, fx_ext_a, fx_ext_op);

    dm_port_arbiter #(.FIXED_PRIO(0), .WAIT_LIMIT(WL)) u_dut (
        .i_clk(clk), .i_reset(reset),
        .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_size(m0_size),
        .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
        .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_size(m1_size),
        .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
        .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err), .o_m0_rdata(o_m0_rdata),
        .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err), .o_m1_rdata(o_m1_rdata),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready),
        .o_ext_a(o_ext_a), .o_ext_op(o_ext_op), .o_ext_din(o_ext_din),
        .i_ext_dout(ext_dout), .o_dbg_state(o_dbg_state)
    );

    dm_port_arbiter #(.FIXED_PRIO(1), .WAIT_LIMIT(WL)) u_fix (
        .i_clk(clk), .i_reset(reset),
        .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_size(m0_size),
        .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
        .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_size(m1_size),
        .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
        .o_m0_ack(fx_m0_ack), .o_m0_err(fx_m0_err), .o_m0_rdata(fx_m0_rdata),
        .o_m1_ack(fx_m1_ack), .o_m1_err(fx_m1_err), .o_m1_rdata(fx_m1_rdata),
        .o_mem_req(fx_mem_req), .o_mem_we(fx_mem_we), .o_mem_addr(fx_mem_addr),
        .o_mem_be(fx_mem_be), .o_mem_wdata(fx_mem_wdata),
        .i_mem_rdata(fx_mem_rdata), .i_mem_ready(mem_ready),
        .o_ext_a(fx_ext_a), .o_ext_op(fx_ext_op), .o_ext_din(fx_ext_din),
        .i_ext_dout(fx_ext_dout), .o_dbg_state(fx_dbg_state)
    );

    // ---------------- check helpers ----------------
    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event not expected or not seen", name);
    endtask

    // ---------------- expectation model ----------------
    task automatic push_expect(input int m, input logic we, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int delay);
        logic        mis, to;
        logic [32:0] e;
        mem_exp_t    me;
        int          n, lo;
        mis = misaligned(addr, size);
        to  = !mis && (delay >= WL);
        e   = {(mis || to), ((mis || to || we) ? 32'd0 : load_result(addr, size))};
        if (m == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        if (!mis && !to) begin
            n  = size_bytes(size);
            lo = int'(addr[1:0]);
            me.we    = we;
            me.addr  = {addr[31:2], 2'b00};
            for (int l = 0; l < 4; l++) begin
                me.be[l] = (l >= lo) && (l < lo + n);
                me.wdata[l*8 +: 8] = wdata[(l % n)*8 +: 8];
            end
            me.ea  = addr[1:0];
            me.eop = (n == 1) ? 3'b010 : ((n == 2) ? 3'b001 : 3'b000);
            mem_q.push_back(me);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int m, input logic req, input logic we,
                           input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_size = size; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_size = size; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    task automatic drop_req(input int m);
        if (m == 0) m0_req = 1'b0;
        else        m1_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_last = 1;
    endtask

    // One access by one master; checks ack latency and mem_req duration.
    task automatic run_single(input int m, input logic we, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int delay);
        int   lat, mr, exp_lat, exp_mr;
        logic mis;
        mis = misaligned(addr, size);
        if (mis) begin
            exp_lat = 1; exp_mr = 0;
        end else if (delay >= WL) begin
            exp_lat = WL + 1; exp_mr = WL;
        end else begin
            exp_lat = delay + 2; exp_mr = delay + 1;
        end
        push_expect(m, we, size, addr, wdata, delay);
        mem_delay = delay;
        @(posedge clk);
        #1;
        set_req(m, 1'b1, we, size, addr, wdata);
        lat = 0;
        mr  = 0;
        for (int c = 1; c <= WL + 8; c++) begin
            @(posedge clk);
            #1;
            if ((m == 0) ? o_m0_ack : o_m1_ack) begin
                lat = c;
                break;
            end
            if (o_mem_req) mr++;
        end
        drop_req(m);
        cmp("ack_latency", 64'(lat), 64'(exp_lat));
        cmp("mem_req_cycles", 64'(mr), 64'(exp_mr));
        model_last = m;
    endtask

    // Both masters request in the same cycle; checks who is served first.
    task automatic run_pair(input int delay);
        logic        we[2];
        logic [1:0]  sz[2];
        logic [31:0] ad[2], wd[2];
        int          w, first;
        logic        done0, done1;
        w = (model_last == 0) ? 1 : 0;
        for (int k = 0; k < 2; k++) begin
            we[k] = 1'($urandom_range(0, 1));
            sz[k] = 2'($urandom_range(0, 3));
            ad[k] = $urandom;
            if ($urandom_range(0, 3) != 0) ad[k][1:0] = ad[k][1:0] & ~2'(size_bytes(sz[k]) - 1);
            wd[k] = $urandom;
        end
        push_expect(w, we[w], sz[w], ad[w], wd[w], delay);
        push_expect(1 - w, we[1-w], sz[1-w], ad[1-w], wd[1-w], delay);
        mem_delay = delay;
        @(posedge clk);
        #1;
        set_req(0, 1'b1, we[0], sz[0], ad[0], wd[0]);
        set_req(1, 1'b1, we[1], sz[1], ad[1], wd[1]);
        first = -1;
        done0 = 1'b0;
        done1 = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (o_m0_ack && !done0) begin
                done0 = 1'b1;
                if (first < 0) first = 0;
                drop_req(0);
            end
            if (o_m1_ack && !done1) begin
                done1 = 1'b1;
                if (first < 0) first = 1;
                drop_req(1);
            end
            if (done0 && done1) break;
        end
        drop_req(0);
        drop_req(1);
        cmp("pair_order", 64'(first), 64'(w));
        cmp("pair_complete", {62'd0, done0, done1}, 64'd3);
        model_last = 1 - w;
    endtask

    // ---------------- monitor: responses ----------------
    always @(negedge clk) begin
        logic [32:0] e;
        if (o_m0_ack && o_m1_ack) fail("dual_ack");
        if (o_m0_ack) begin
            if (exp_q0.size() == 0) fail("m0_ack_unexpected");
            else begin
                e = exp_q0.pop_front();
                cmp("m0_resp", {31'd0, o_m0_err, o_m0_rdata}, {31'd0, e});
            end
        end
        if (o_m1_ack) begin
            if (exp_q1.size() == 0) fail("m1_ack_unexpected");
            else begin
                e = exp_q1.pop_front();
                cmp("m1_resp", {31'd0, o_m1_err, o_m1_rdata}, {31'd0, e});
            end
        end
    end

    // ---------------- memory model + command checker ----------------
    always @(negedge clk) begin
        mem_exp_t me;
        if (o_mem_req) begin
            if (busy_cnt == mem_delay) begin
                mem_ready = 1'b1;
                if (mem_q.size() == 0) fail("mem_unexpected");
                else begin
                    me = mem_q.pop_front();
                    cmp("mem_cmd", {27'd0, o_mem_we, o_mem_addr, o_mem_be},
                        {27'd0, me.we, me.addr, me.be});
                    if (me.we) cmp("mem_wdata", 64'(o_mem_wdata), 64'(me.wdata));
                    cmp("ext_ctl", {59'd0, o_ext_a, o_ext_op}, {59'd0, me.ea, me.eop});
                end
            end else begin
                mem_ready = 1'b0;
            end
            busy_cnt++;
        end else begin
            busy_cnt  = 0;
            mem_ready = 1'b0;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int          w, got;
        logic [31:0] c_wd;
        mem_ready = 1'b0;
        set_req(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        set_req(1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        do_reset();

        // reset values
        cmp("reset_ctl", {50'd0, o_m0_ack, o_m1_ack, o_m0_err, o_m1_err, o_mem_req,
                          o_mem_we, o_mem_be, o_ext_a, o_ext_op}, 64'd0);
        cmp("reset_state", 64'(o_dbg_state), 64'd0);
        cmp("reset_addr_wdata", {o_mem_addr, o_mem_wdata}, 64'd0);
        cmp("reset_ext_din", 64'(o_ext_din), 64'd0);
        cmp("reset_rdata", {o_m0_rdata, o_m1_rdata}, 64'd0);

        // byte load at 0x1003 from word 0x80FF_FF00, then half store at 0x22
        run_single(0, 1'b0, 2'b10, 32'h0000_1003, 32'd0, 0);
        run_single(1, 1'b1, 2'b01, 32'h0000_0022, 32'h0000_BEEF, 0);

        // misaligned accesses: no memory strobe, ack with err one cycle later
        run_single(0, 1'b0, 2'b00, 32'h0000_0006, 32'd0, 0);
        run_single(0, 1'b0, 2'b01, 32'h0000_0005, 32'd0, 0);

        // memory never ready: timeout after WL busy cycles
        run_single(0, 1'b0, 2'b00, 32'h0000_0080, 32'd0, 1000);
        run_single(1, 1'b1, 2'b10, 32'h0000_0091, 32'h0000_00A5, 1000);

        // randomized single accesses, some with extra wait cycles or timeouts
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  sz;
            logic [31:0] ad;
            int          dl;
            sz = 2'($urandom_range(0, 3));
            ad = $urandom;
            if ($urandom_range(0, 3) != 0) ad[1:0] = ad[1:0] & ~2'(size_bytes(sz) - 1);
            dl = ($urandom_range(0, 7) == 0) ? WL : $urandom_range(0, 2);
            run_single($urandom_range(0, 1), 1'($urandom_range(0, 1)), sz, ad, $urandom, dl);
        end

        // simultaneous requests: round-robin tie breaking
        for (int i = 0; i < 12; i++) begin
            run_pair($urandom_range(0, 2));
        end

        // continuous requests from both masters
        do_reset();
        mem_delay = 0;
        c_wd = $urandom;
        @(posedge clk);
        #1;
        set_req(0, 1'b1, 1'b0, 2'b00, 32'h0000_0100, 32'd0);
        set_req(1, 1'b1, 1'b1, 2'b10, 32'h0000_0203, c_wd);
        for (int k = 0; k < 8; k++) begin
            w = (model_last == 0) ? 1 : 0;
            if (w == 0) push_expect(0, 1'b0, 2'b00, 32'h0000_0100, 32'd0, 0);
            else        push_expect(1, 1'b1, 2'b10, 32'h0000_0203, c_wd, 0);
            got = -1;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk);
                #1;
                if (o_m0_ack) got = 0;
                else if (o_m1_ack) got = 1;
                if (got >= 0) break;
            end
            cmp("rr_grant", 64'(got), 64'(w));
            cmp("fixed_grant", {62'd0, fx_m0_ack, fx_m1_ack}, 64'd2);
            cmp("fixed_rdata", 64'(fx_m0_rdata), 64'(mem_word(32'h0000_0100)));
            model_last = w;
        end
        drop_req(0);
        drop_req(1);

        // reset while BUSY: strobe drops, no ack, next access is normal
        mem_delay = 1000;
        @(posedge clk);
        #1;
        set_req(0, 1'b1, 1'b0, 2'b00, 32'h0000_0040, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        cmp("busy_before_reset", {62'd0, o_mem_req, 1'b0}, 64'd2);
        reset = 1'b1;
        drop_req(0);
        @(posedge clk);
        #1;
        cmp("reset_mid_mem_req", 64'(o_mem_req), 64'd0);
        cmp("reset_mid_state", 64'(o_dbg_state), 64'd0);
        cmp("reset_mid_ack", {62'd0, o_m0_ack, o_m1_ack}, 64'd0);
        reset = 1'b0;
        model_last = 1;
        repeat (3) @(posedge clk);
        run_single(0, 1'b0, 2'b01, 32'h0000_0042, 32'd0, 1);

        repeat (4) @(posedge clk);
        cmp("leftover_resp", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
        cmp("leftover_mem", 64'(mem_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single data-memory/bridge port between two requesters: m0 = CPU M-stage load/store, m1 = auxiliary master (debug/DMA).
- Sequences each access through the port and generates byte enables and lane-shifted store data.
- For loads, drives the address low bits and op code of the load-extension unit and returns its sign-extended result to the requester.
- Detects misaligned accesses and times out accesses the memory never completes.

Parameters:
- FIXED_PRIO, 0, 1 = m0 always wins; 0 = round-robin between m0 and m1.
- WAIT_LIMIT, 255, maximum BUSY cycles without mem_ready before the access is aborted with an error (1..255).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m0_req, m1_req  in  1  access request, level; held until ack
- m0_we, m1_we  in  1  1 = store, 0 = load
- m0_size, m1_size  in  2  00 word, 01 half, 10 byte, 11 treated as word
- m0_addr, m1_addr  in  32  byte address
- m0_wdata, m1_wdata  in  32  store data, right-aligned
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_err, m1_err  out  1  valid with ack; 1 = misaligned or timeout
- m0_rdata, m1_rdata  out  32  load result, valid with ack
- mem_req  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  32  word-aligned address, {addr[31:2], 2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  raw read word
- mem_ready  in  1  access complete, sampled while mem_req = 1
- ext_a  out  2  addr[1:0] of the latched request, to the extension unit
- ext_op  out  3  000 word, 001 half, 010 byte, to the extension unit
- ext_din  out  32  latched read word, to the extension unit
- ext_dout  in  32  extended result from the extension unit

Behaviour:
- States: IDLE, BUSY, DONE, ERR. All registered outputs reset to 0; state resets to IDLE; rr pointer resets to favour m0; wait counter resets to 0.
- IDLE, arbitration:
  - If any req is high, pick the grantee. FIXED_PRIO = 1: m0 first. Otherwise the last-granted master loses a tie. A lone requester always wins.
  - Latch we, size, addr and wdata of the grantee; record the grantee id.
- IDLE, alignment check:
  - Misaligned means half with addr[0] = 1, or word with addr[1:0] != 0.
  - Misaligned -> ERR; otherwise -> BUSY and clear the wait counter.
- BUSY:
  - mem_req = 1, with mem_we/addr/be/wdata taken from the latched fields.
  - mem_ready = 1 -> latch mem_rdata into ext_din (loads only) and go to DONE.
  - Otherwise increment the counter; if it reaches WAIT_LIMIT -> ERR, and mem_req drops.
- DONE:
  - ack = 1 for the grantee only, with err = 0.
  - rdata = ext_dout for loads, 0 for stores.
  - Update the rr pointer, then go to IDLE.
- ERR:
  - ack = 1 and err = 1 for the grantee, rdata = 0.
  - Update the rr pointer, then go to IDLE. Memory is never accessed for a misaligned request.
- Byte enables:
  - word: be = 1111, wdata = wdata.
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - byte: be = 0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - Loads drive the same be.
- ext_op is derived from the latched size: 00/11 -> 000, 01 -> 001, 10 -> 010. ext_a = latched addr[1:0].
- Latency: req first high at cycle t -> mem_req at t+1. If mem_ready is high at t+1, ack is at t+2. Minimum 3 cycles per access. Each cycle of mem_ready delay adds one cycle.
- Misaligned access: ack with err at t+1.
- A requester must drop or change req in the cycle after ack; a req still high in IDLE is a new request.
- The non-granted master's ack stays 0 throughout; its request stays pending.
- A request change by the grantee while BUSY is ignored, because fields are latched.
- Reset in any state: IDLE on the next edge, mem_req = 0, no ack issued, pending access discarded.

Test Plan:
- Reset -> all outputs 0. m0 load byte at addr 0x1003, mem_rdata 0x80FF_FF00, mem_ready at the first BUSY cycle -> mem_be = 1000, ext_op = 010, ext_a = 11, m0_ack at t+2, m0_rdata 0xFFFF_FF80.
- m1 store half at 0x22, wdata 0x0000_BEEF -> mem_addr 0x20, mem_be 1100, mem_wdata 0xBEEF_BEEF, mem_we = 1, m1_ack at t+2 with err = 0.
- m0 and m1 request continuously, FIXED_PRIO = 0 -> grants alternate m0, m1, m0, m1; each ack goes to the correct master only. FIXED_PRIO = 1 -> m0 every time.
- m0 word load at 0x6 -> no mem_req, m0_ack and m0_err at t+1; m0 half at 0x5 -> same.
- mem_ready held low, WAIT_LIMIT = 4 -> mem_req high for 4 cycles, then ack with err = 1 and mem_req low.
- Reset asserted during BUSY -> mem_req 0 and state IDLE at the next edge, no ack; subsequent request completes normally.
